// File: rtl/serv_ibus_fetch_pkg.sv
// Shared definitions for the instruction-fetch initiator: FSM encoding and
// the Wishbone word-address width.
package serv_ibus_fetch_pkg;

  localparam int ADR_W = 30;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_DELIVER = 3'd2;
  localparam logic [2:0] ST_PF_BUS  = 3'd3;
  localparam logic [2:0] ST_PF_HELD = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    FETCH   = ST_FETCH,
    DELIVER = ST_DELIVER,
    PF_BUS  = ST_PF_BUS,
    PF_HELD = ST_PF_HELD
  } state_t;

endpackage

// File: rtl/serv_ibus_pfbuf.sv
// One-entry prefetch buffer: holds one instruction word tagged with its word
// address. Clear wins over load when both are asserted in the same cycle.
module serv_ibus_pfbuf
  import serv_ibus_fetch_pkg::*;
(
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [31:0]      i_data,
  input  logic [ADR_W-1:0] i_tag,
  input  logic [ADR_W-1:0] i_cmp_tag,
  output logic [31:0]      o_data,
  output logic             o_hit
);

  logic             valid_q;
  logic [ADR_W-1:0] tag_q;
  logic [31:0]      data_q;

  // Entry storage: load captures word and tag, clear invalidates.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (i_clear) begin
      valid_q <= 1'b0;
    end else if (i_load) begin
      valid_q <= 1'b1;
      tag_q   <= i_tag;
      data_q  <= i_data;
    end
  end

  assign o_data = data_q;
  assign o_hit  = valid_q && (tag_q == i_cmp_tag);

endmodule

// File: rtl/serv_ibus_fetch.sv
// Instruction-fetch initiator on a Wishbone classic read bus.
// Optional next-word prefetch is enabled by defining SERV_IBUS_PREFETCH_EN.
//
// Handshake: i_fetch_req is a one-cycle pulse accepted only while o_busy=0;
// the fetched word is presented on o_rdt while o_rdt_valid pulses for exactly
// one cycle, and there is no backpressure from the consumer. On the bus,
// o_ibus_cyc and o_ibus_adr stay stable until the cycle in which i_ibus_ack=1.
module serv_ibus_fetch
  import serv_ibus_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter bit          WITH_RESET_FETCH = 1'b1
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_fetch_req,
  input  logic [31:0]      i_pc,
  input  logic             i_flush,
  output logic [ADR_W-1:0] o_ibus_adr,
  output logic             o_ibus_cyc,
  input  logic [31:0]      i_ibus_rdt,
  input  logic             i_ibus_ack,
  output logic [31:0]      o_rdt,
  output logic             o_rdt_valid,
  output logic             o_misalign,
  output logic             o_busy,
  output state_t           o_dbg_state
);

  state_t           state_q, state_d;
  logic             first_q;
  logic [ADR_W-1:0] adr_d;
  logic             cyc_d, valid_d, mis_d, busy_d;
  logic [31:0]      rdt_d;

  // The first cycle after reset release can act as a fetch of RESET_PC.
  logic        req;
  logic [31:0] req_pc;
  logic        req_ok;
  assign req    = i_fetch_req | first_q;
  assign req_pc = first_q ? RESET_PC : i_pc;
  assign req_ok = (req_pc[1:0] == 2'b00);

`ifdef SERV_IBUS_PREFETCH_EN
  // Pending-request bookkeeping while a prefetch read is on the bus.
  logic             pf_hit_q, pf_redir_q, pf_new_q;
  logic [ADR_W-1:0] pf_adr_q;
  logic             pf_hit_d, pf_redir_d, pf_new_d;
  logic [ADR_W-1:0] pf_adr_d;
  logic             eff_hit, eff_redir, eff_new;
  logic [ADR_W-1:0] eff_adr;
  logic             buf_load, buf_clear, buf_hit;
  logic [31:0]      buf_data;

  serv_ibus_pfbuf u_pfbuf (
    .clk       (clk),
    .i_rst     (i_rst),
    .i_load    (buf_load),
    .i_clear   (buf_clear),
    .i_data    (i_ibus_rdt),
    .i_tag     (o_ibus_adr),
    .i_cmp_tag (req_pc[31:2]),
    .o_data    (buf_data),
    .o_hit     (buf_hit)
  );
`else
  logic unused_flush;
  assign unused_flush = i_flush;
`endif

  // Next-state and next-output computation; every register holds by default.
  always_comb begin
    state_d = state_q;
    adr_d   = o_ibus_adr;
    cyc_d   = o_ibus_cyc;
    rdt_d   = o_rdt;
    valid_d = 1'b0;
    mis_d   = 1'b0;
    busy_d  = o_busy;
`ifdef SERV_IBUS_PREFETCH_EN
    pf_hit_d   = pf_hit_q;
    pf_redir_d = pf_redir_q;
    pf_new_d   = pf_new_q;
    pf_adr_d   = pf_adr_q;
    eff_hit    = pf_hit_q;
    eff_redir  = pf_redir_q;
    eff_new    = pf_new_q;
    eff_adr    = pf_adr_q;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_ok) begin
            adr_d   = req_pc[31:2];
            cyc_d   = 1'b1;
            busy_d  = 1'b1;
            state_d = FETCH;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (i_ibus_ack) begin
          rdt_d   = i_ibus_rdt;
          cyc_d   = 1'b0;
          valid_d = 1'b1;
          state_d = DELIVER;
        end
      end
      DELIVER: begin
        busy_d = 1'b0;
`ifdef SERV_IBUS_PREFETCH_EN
        adr_d      = o_ibus_adr + ADR_W'(1);
        cyc_d      = 1'b1;
        pf_hit_d   = 1'b0;
        pf_redir_d = 1'b0;
        pf_new_d   = 1'b0;
        state_d    = PF_BUS;
`else
        state_d = IDLE;
`endif
      end
`ifdef SERV_IBUS_PREFETCH_EN
      PF_BUS: begin
        // A flush discards the in-flight word and any request waiting on it.
        if (i_flush) begin
          eff_redir = 1'b1;
          eff_hit   = 1'b0;
          eff_new   = 1'b0;
          busy_d    = 1'b0;
          buf_clear = 1'b1;
        end
        if (req && !(eff_hit || eff_new)) begin
          if (!req_ok) begin
            mis_d = 1'b1;
          end else if (!eff_redir && (req_pc[31:2] == o_ibus_adr)) begin
            eff_hit = 1'b1;
            busy_d  = 1'b1;
          end else begin
            eff_redir = 1'b1;
            eff_new   = 1'b1;
            eff_adr   = req_pc[31:2];
            busy_d    = 1'b1;
          end
        end
        if (i_ibus_ack) begin
          pf_hit_d   = 1'b0;
          pf_redir_d = 1'b0;
          pf_new_d   = 1'b0;
          if (eff_hit) begin
            rdt_d   = i_ibus_rdt;
            valid_d = 1'b1;
            cyc_d   = 1'b0;
            state_d = DELIVER;
          end else if (eff_redir) begin
            if (eff_new) begin
              adr_d   = eff_adr;
              state_d = FETCH;
            end else begin
              cyc_d   = 1'b0;
              state_d = IDLE;
            end
          end else begin
            buf_load = 1'b1;
            cyc_d    = 1'b0;
            state_d  = PF_HELD;
          end
        end else begin
          pf_hit_d   = eff_hit;
          pf_redir_d = eff_redir;
          pf_new_d   = eff_new;
          pf_adr_d   = eff_adr;
        end
      end
      PF_HELD: begin
        if (i_flush) begin
          buf_clear = 1'b1;
          state_d   = IDLE;
        end
        if (req) begin
          if (!req_ok) begin
            mis_d = 1'b1;
          end else if (!i_flush && buf_hit) begin
            rdt_d     = buf_data;
            valid_d   = 1'b1;
            busy_d    = 1'b1;
            buf_clear = 1'b1;
            state_d   = DELIVER;
          end else begin
            buf_clear = 1'b1;
            adr_d     = req_pc[31:2];
            cyc_d     = 1'b1;
            busy_d    = 1'b1;
            state_d   = FETCH;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset drops the bus cycle immediately.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      first_q     <= WITH_RESET_FETCH;
      o_ibus_adr  <= '0;
      o_ibus_cyc  <= 1'b0;
      o_rdt       <= '0;
      o_rdt_valid <= 1'b0;
      o_misalign  <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      state_q     <= state_d;
      first_q     <= 1'b0;
      o_ibus_adr  <= adr_d;
      o_ibus_cyc  <= cyc_d;
      o_rdt       <= rdt_d;
      o_rdt_valid <= valid_d;
      o_misalign  <= mis_d;
      o_busy      <= busy_d;
    end
  end

`ifdef SERV_IBUS_PREFETCH_EN
  // Prefetch bookkeeping registers.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      pf_hit_q   <= 1'b0;
      pf_redir_q <= 1'b0;
      pf_new_q   <= 1'b0;
      pf_adr_q   <= '0;
    end else begin
      pf_hit_q   <= pf_hit_d;
      pf_redir_q <= pf_redir_d;
      pf_new_q   <= pf_new_d;
      pf_adr_q   <= pf_adr_d;
    end
  end
`endif

  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_serv_ibus_fetch.sv
// Directed bench for serv_ibus_fetch (RESET_PC=0x40, reset fetch enabled).
// Covers the prefetch path when SERV_IBUS_PREFETCH_EN is defined.
module tb_serv_ibus_fetch;
  import serv_ibus_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] pc = '0;
  logic        flush = 1'b0;
  logic [29:0] ibus_adr;
  logic        ibus_cyc;
  logic [31:0] ibus_rdt = '0;
  logic        ibus_ack = 1'b0;
  logic [31:0] rdt;
  logic        rdt_valid;
  logic        misalign;
  logic        busy;
  state_t      dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // Clock
  always #5 clk = ~clk;

  serv_ibus_fetch #(
    .RESET_PC         (32'h0000_0040),
    .WITH_RESET_FETCH (1'b1)
  ) dut (
    .clk         (clk),
    .i_rst       (rst),
    .i_fetch_req (fetch_req),
    .i_pc        (pc),
    .i_flush     (flush),
    .o_ibus_adr  (ibus_adr),
    .o_ibus_cyc  (ibus_cyc),
    .i_ibus_rdt  (ibus_rdt),
    .i_ibus_ack  (ibus_ack),
    .o_rdt       (rdt),
    .o_rdt_valid (rdt_valid),
    .o_misalign  (misalign),
    .o_busy      (busy),
    .o_dbg_state (dbg_state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [31:0] a);
    fetch_req = 1'b1;
    pc        = a;
    step();
    fetch_req = 1'b0;
  endtask

  task automatic ack(input logic [31:0] d);
    ibus_ack = 1'b1;
    ibus_rdt = d;
    step();
    ibus_ack = 1'b0;
  endtask

  initial begin
    // Reset values
    step(); step(); step();
    chk("rst_cyc",   32'(ibus_cyc),  32'd0);
    chk("rst_adr",   32'(ibus_adr),  32'd0);
    chk("rst_rdt",   rdt,            32'd0);
    chk("rst_valid", 32'(rdt_valid), 32'd0);
    chk("rst_mis",   32'(misalign),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Automatic fetch of RESET_PC after release
    rst = 1'b0;
    step();
    chk("boot_cyc",  32'(ibus_cyc), 32'd1);
    chk("boot_adr",  32'(ibus_adr), 32'h10);
    chk("boot_busy", 32'(busy),     32'd1);
    ack(32'h1111_1111);
    chk("boot_valid", 32'(rdt_valid), 32'd1);
    chk("boot_rdt",   rdt,            32'h1111_1111);
    step();
    chk("boot_strobe_end", 32'(rdt_valid), 32'd0);

`ifndef SERV_IBUS_PREFETCH_EN
    chk("boot_idle_cyc",  32'(ibus_cyc), 32'd0);
    chk("boot_idle_busy", 32'(busy),     32'd0);

    // Aligned fetch, zero-wait slave
    req(32'h0000_0100);
    chk("zw_cyc",   32'(ibus_cyc),  32'd1);
    chk("zw_adr",   32'(ibus_adr),  32'h40);
    chk("zw_valid0", 32'(rdt_valid), 32'd0);
    ack(32'h00A0_0093);
    chk("zw_valid", 32'(rdt_valid), 32'd1);
    chk("zw_rdt",   rdt,            32'h00A0_0093);
    chk("zw_cyc_off", 32'(ibus_cyc), 32'd0);
    step();
    chk("zw_valid_end", 32'(rdt_valid), 32'd0);
    chk("zw_busy_end",  32'(busy),      32'd0);

    // Wait states, with a protocol-error request mid-fetch
    req(32'h0000_0200);
    step();
    chk("ws1_cyc", 32'(ibus_cyc), 32'd1);
    chk("ws1_adr", 32'(ibus_adr), 32'h80);
    req(32'h0000_0300);
    chk("ws2_adr",  32'(ibus_adr),  32'h80);
    chk("ws2_busy", 32'(busy),      32'd1);
    step();
    chk("ws3_cyc",   32'(ibus_cyc),  32'd1);
    chk("ws3_adr",   32'(ibus_adr),  32'h80);
    chk("ws3_valid", 32'(rdt_valid), 32'd0);
    ack(32'hDEAD_BEEF);
    chk("ws_valid", 32'(rdt_valid), 32'd1);
    chk("ws_rdt",   rdt,            32'hDEAD_BEEF);
    chk("ws_busy",  32'(busy),      32'd1);
    step();
    chk("ws_valid_end", 32'(rdt_valid), 32'd0);
    step();
    chk("ws_single", 32'(rdt_valid), 32'd0);
    chk("ws_no_cyc", 32'(ibus_cyc),  32'd0);

    // Misaligned request
    req(32'h0000_0102);
    chk("mis_pulse", 32'(misalign), 32'd1);
    chk("mis_cyc",   32'(ibus_cyc), 32'd0);
    chk("mis_state", 32'(dbg_state), 32'(ST_IDLE));
    step();
    chk("mis_end",  32'(misalign), 32'd0);
    chk("mis_cyc2", 32'(ibus_cyc), 32'd0);

    // Reset mid-fetch, ack after release ignored, then refetch RESET_PC
    req(32'h0000_0300);
    chk("rmf_cyc", 32'(ibus_cyc), 32'd1);
    chk("rmf_adr", 32'(ibus_adr), 32'hC0);
    rst = 1'b1;
    #1;
    chk("rmf_async_cyc", 32'(ibus_cyc), 32'd0);
    step();
    rst      = 1'b0;
    ibus_ack = 1'b1;
    ibus_rdt = 32'hBAD0_BAD0;
    step();
    ibus_ack = 1'b0;
    chk("rmf_no_valid", 32'(rdt_valid), 32'd0);
    chk("rmf_cyc2",     32'(ibus_cyc),  32'd1);
    chk("rmf_adr2",     32'(ibus_adr),  32'h10);
    step();
    chk("rmf_still_fetch", 32'(rdt_valid), 32'd0);
    ack(32'h2222_2222);
    chk("rmf_valid", 32'(rdt_valid), 32'd1);
    chk("rmf_rdt",   rdt,            32'h2222_2222);
    step();
    chk("rmf_busy_end", 32'(busy), 32'd0);
`else
    // Prefetch of the next word starts straight after delivery
    chk("pf_state", 32'(dbg_state), 32'(ST_PF_BUS));
    chk("pf_cyc",   32'(ibus_cyc),  32'd1);
    chk("pf_adr",   32'(ibus_adr),  32'h11);
    chk("pf_busy",  32'(busy),      32'd0);

    // Flush during the prefetch read, then request 0x200
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_cyc_held", 32'(ibus_cyc), 32'd1);
    chk("fl_adr_held", 32'(ibus_adr), 32'h11);
    req(32'h0000_0200);
    chk("fl_busy", 32'(busy),     32'd1);
    chk("fl_adr",  32'(ibus_adr), 32'h11);
    ack(32'h3333_3333);
    chk("fl_discard", 32'(rdt_valid), 32'd0);
    chk("fl_new_adr", 32'(ibus_adr),  32'h80);
    chk("fl_new_cyc", 32'(ibus_cyc),  32'd1);
    step();
    chk("fl_wait_valid", 32'(rdt_valid), 32'd0);
    ack(32'h4444_4444);
    chk("fl_valid", 32'(rdt_valid), 32'd1);
    chk("fl_rdt",   rdt,            32'h4444_4444);
    step();
    chk("fl_valid_end", 32'(rdt_valid), 32'd0);
    chk("pf2_adr",      32'(ibus_adr),  32'h81);

    // Prefetch lands in the buffer, then a matching request hits it
    ack(32'h5555_5555);
    chk("held_state", 32'(dbg_state), 32'(ST_PF_HELD));
    chk("held_cyc",   32'(ibus_cyc),  32'd0);
    chk("held_valid", 32'(rdt_valid), 32'd0);
    req(32'h0000_0204);
    chk("hit_valid", 32'(rdt_valid), 32'd1);
    chk("hit_rdt",   rdt,            32'h5555_5555);
    chk("hit_no_cyc", 32'(ibus_cyc), 32'd0);
    step();
    chk("hit_next_adr", 32'(ibus_adr), 32'h82);
    chk("hit_next_cyc", 32'(ibus_cyc), 32'd1);

    // Matching request while the prefetch is still on the bus
    req(32'h0000_0208);
    chk("bus_hit_busy",  32'(busy),      32'd1);
    chk("bus_hit_wait",  32'(rdt_valid), 32'd0);
    ack(32'h6666_6666);
    chk("bus_hit_valid", 32'(rdt_valid), 32'd1);
    chk("bus_hit_rdt",   rdt,            32'h6666_6666);
    step();
    chk("bus_hit_next", 32'(ibus_adr), 32'h83);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
